lcd_text_writer: RTL and testbench

- Upstream feeder for the LCD character controller; drives its lcd_enable / lcd_bus / busy command interface.
- Holds one display line of characters in an internal buffer, loaded by the host.
- On start, issues an optional clear, a DDRAM set-address command, then every buffered character as a data write.
- Performs one handshake per item and reports completion or an acknowledge timeout.

---
 rtl/lcd_text_writer.sv | 152 +++++++++++++++
 tb/tb_lcd_text_writer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_writer.sv
// rtl/lcd_text_writer.sv - writes one buffered text line to the LCD character controller
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   wr_en/wr_addr/wr_char host write port into the line buffer (ignored while xfer_busy)
//   start/line_sel/clear_first  begin a line transfer (sampled in IDLE only)
//   busy                  busy handshake from the LCD controller
//   lcd_enable/lcd_bus    one-cycle command strobe and {rs, rw, data} to the controller
//   xfer_busy/done/err    transfer status, done/err are one-cycle pulses

module lcd_text_writer #(
    parameter int LINE_LEN    = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_char,
    input  logic       start,
    input  logic       line_sel,
    input  logic       clear_first,
    input  logic       busy,
    output logic       lcd_enable,
    output logic [9:0] lcd_bus,
    output logic       xfer_busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    localparam int             CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [4:0]     LEN5     = 5'(LINE_LEN);
    localparam logic [CW-1:0]  ACK_LAST = CW'(ACK_TIMEOUT - 1);

    state_t        state;
    logic [7:0]    line_buf [16];
    logic          clr_lat;
    logic          line_lat;
    logic [4:0]    item_idx;
    logic [CW-1:0] ack_cnt;

    logic [4:0]    last_idx;
    logic [4:0]    next_idx;
    logic [3:0]    data_idx;
    logic [9:0]    next_item;

    // Item numbering: [clear], address, then characters 0..LINE_LEN-1.
    // The item loaded at start is never a character, so the "next" item is
    // either the address (only when a clear went first) or a character.
    always_comb begin
        last_idx  = LEN5 + {4'b0, clr_lat};
        next_idx  = item_idx + 5'd1;
        data_idx  = next_idx[3:0] - {3'b0, clr_lat} - 4'd1;
        next_item = {2'b10, line_buf[data_idx]};
        if (clr_lat && (next_idx == 5'd1)) begin
            next_item = {3'b001, line_lat, 6'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                line_buf[i] <= 8'h20;
            end
        end else if (wr_en && !xfer_busy && ({1'b0, wr_addr} < LEN5)) begin
            line_buf[wr_addr] <= wr_char;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lcd_enable <= 1'b0;
            lcd_bus    <= 10'h000;
            xfer_busy  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            clr_lat    <= 1'b0;
            line_lat   <= 1'b0;
            item_idx   <= 5'd0;
            ack_cnt    <= '0;
        end else begin
            lcd_enable <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        clr_lat   <= clear_first;
                        line_lat  <= line_sel;
                        item_idx  <= 5'd0;
                        lcd_bus   <= clear_first ? 10'h001 : {3'b001, line_sel, 6'b0};
                        xfer_busy <= 1'b1;
                        state     <= S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (!busy) begin
                        lcd_enable <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ack_cnt <= '0;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (busy) begin
                        state <= S_WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        err       <= 1'b1;
                        xfer_busy <= 1'b0;
                        lcd_bus   <= 10'h000;
                        state     <= S_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!busy) begin
                        if (item_idx == last_idx) begin
                            done      <= 1'b1;
                            xfer_busy <= 1'b0;
                            lcd_bus   <= 10'h000;
                            state     <= S_FINISH;
                        end else begin
                            item_idx <= next_idx;
                            lcd_bus  <= next_item;
                            state    <= S_WAIT_RDY;
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_writer.sv
// tb/tb_lcd_text_writer.sv - self-checking bench for lcd_text_writer

module tb_lcd_text_writer;

    localparam int LINE_LEN    = 16;
    localparam int ACK_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_char = 8'd0;
    logic       start = 1'b0;
    logic       line_sel = 1'b0;
    logic       clear_first = 1'b0;
    logic       lcd_enable;
    logic [9:0] lcd_bus;
    logic       xfer_busy;
    logic       done;
    logic       err;

    logic       hold_busy = 1'b0;
    logic       respond = 1'b1;
    logic       ctl_busy = 1'b0;
    wire        busy = ctl_busy | hold_busy;

    lcd_text_writer #(.LINE_LEN(LINE_LEN), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .start(start), .line_sel(line_sel), .clear_first(clear_first), .busy(busy),
        .lcd_enable(lcd_enable), .lcd_bus(lcd_bus), .xfer_busy(xfer_busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Controller model and event recorder
    logic [9:0] bus_q[$];
    int cyc = 0, en_cnt = 0, done_cnt = 0, err_cnt = 0, bad_en = 0;
    int last_en_cyc = 0, last_err_cyc = 0, busy_cnt = 0;
    bit pend = 0, prev_en = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            ctl_busy = 1'b0;
            pend     = 0;
            busy_cnt = 0;
            prev_en  = 0;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) ctl_busy = 1'b0;
            end else if (pend) begin
                pend     = 0;
                ctl_busy = 1'b1;
                busy_cnt = 5;
            end
            if (lcd_enable) begin
                bus_q.push_back(lcd_bus);
                en_cnt++;
                last_en_cyc = cyc;
                if (respond) pend = 1;
                if (prev_en) bad_en++;
            end
            prev_en = lcd_enable;
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                last_err_cyc = cyc;
            end
        end
    end

    // Reference model: buffer contents and expected item list
    logic [7:0] model_buf [16];
    logic [9:0] exp_q[$];
    int checks = 0, errors = 0;
    int base_q, base_done, base_err, base_en;
    bit tmo;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_buf[i] = 8'h20;
    endtask

    task automatic build_exp(input logic clr, input logic line);
        exp_q.delete();
        if (clr) exp_q.push_back(10'h001);
        exp_q.push_back(line ? 10'h0C0 : 10'h080);
        for (int i = 0; i < LINE_LEN; i++) exp_q.push_back({2'b10, model_buf[i]});
    endtask

    task automatic mark_base();
        base_q    = bus_q.size();
        base_done = done_cnt;
        base_err  = err_cnt;
        base_en   = en_cnt;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] c);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_char = c;
        model_buf[a] = c;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_end(output bit timed_out);
        timed_out = 1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #1;
            if (done_cnt != base_done || err_cnt != base_err) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic run_xfer(input logic clr, input logic line, input bit wr0,
                            input logic [7:0] c0, output bit timed_out);
        mark_base();
        @(negedge clk);
        start = 1'b1; clear_first = clr; line_sel = line;
        if (wr0) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_char = c0;
            model_buf[0] = c0;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        wait_end(timed_out);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (lcd_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%0b exp=0", lcd_enable); end
        checks++; if (lcd_bus !== 10'h000) begin errors++; $display("FAIL reset_bus got=%h exp=000", lcd_bus); end
        checks++; if ({xfer_busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_status got=%b exp=000", {xfer_busy, done, err}); end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++; if ({lcd_enable, xfer_busy, done, err} !== 4'b0000) begin errors++; $display("FAIL post_reset_idle got=%b exp=0000", {lcd_enable, xfer_busy, done, err}); end
    endtask

    task automatic test_default_line();
        build_exp(1'b0, 1'b0);
        run_xfer(1'b0, 1'b0, 0, 8'h00, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL default_timeout got=timeout exp=done"); end
        checks++; if (bus_q.size() - base_q != exp_q.size()) begin errors++; $display("FAIL default_pulses got=%0d exp=%0d", bus_q.size() - base_q, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base_q + i < bus_q.size()) begin
                checks++; if (bus_q[base_q + i] !== exp_q[i]) begin errors++; $display("FAIL default_item%0d got=%h exp=%h", i, bus_q[base_q + i], exp_q[i]); end
            end
        end
        checks++; if (done_cnt - base_done != 1) begin errors++; $display("FAIL default_done got=%0d exp=1", done_cnt - base_done); end
        checks++; if (xfer_busy !== 1'b0 || lcd_bus !== 10'h000) begin errors++; $display("FAIL default_end got=%b/%h exp=0/000", xfer_busy, lcd_bus); end
    endtask

    task automatic test_hello();
        logic [7:0] txt [5];
        txt[0] = "H"; txt[1] = "E"; txt[2] = "L"; txt[3] = "L"; txt[4] = "O";
        for (int i = 0; i < 5; i++) host_write(4'(i), txt[i]);
        build_exp(1'b1, 1'b1);
        run_xfer(1'b1, 1'b1, 0, 8'h00, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL hello_timeout got=timeout exp=done"); end
        checks++; if (bus_q.size() - base_q != 18) begin errors++; $display("FAIL hello_pulses got=%0d exp=18", bus_q.size() - base_q); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base_q + i < bus_q.size()) begin
                checks++; if (bus_q[base_q + i] !== exp_q[i]) begin errors++; $display("FAIL hello_item%0d got=%h exp=%h", i, bus_q[base_q + i], exp_q[i]); end
            end
        end
        checks++; if (done_cnt - base_done != 1) begin errors++; $display("FAIL hello_done got=%0d exp=1", done_cnt - base_done); end
    endtask

    task automatic test_random();
        logic c, l;
        logic [7:0] c0;
        for (int it = 0; it < 4; it++) begin
            for (int w = 0; w < int'($urandom_range(0, 12)); w++)
                host_write(4'($urandom_range(0, 15)), 8'($urandom));
            c  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1));
            c0 = 8'($urandom);
            model_buf[0] = c0;
            build_exp(c, l);
            run_xfer(c, l, 1, c0, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL rand%0d_timeout got=timeout exp=done", it); end
            checks++; if (bus_q.size() - base_q != exp_q.size()) begin errors++; $display("FAIL rand%0d_pulses got=%0d exp=%0d", it, bus_q.size() - base_q, exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                if (base_q + i < bus_q.size()) begin
                    checks++; if (bus_q[base_q + i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_item%0d got=%h exp=%h", it, i, bus_q[base_q + i], exp_q[i]); end
                end
            end
        end
    endtask

    task automatic test_busy_hold();
        build_exp(1'b0, 1'b0);
        mark_base();
        @(negedge clk);
        hold_busy = 1'b1;
        start = 1'b1; clear_first = 1'b0; line_sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        checks++; if (en_cnt != base_en) begin errors++; $display("FAIL hold_no_enable got=%0d exp=0", en_cnt - base_en); end
        checks++; if (xfer_busy !== 1'b1) begin errors++; $display("FAIL hold_xfer_busy got=%b exp=1", xfer_busy); end
        hold_busy = 1'b0;
        @(negedge clk);
        checks++; if (lcd_enable !== 1'b1) begin errors++; $display("FAIL hold_first_pulse got=%b exp=1", lcd_enable); end
        wait_end(tmo);
        checks++; if (tmo || bus_q.size() - base_q != exp_q.size()) begin errors++; $display("FAIL hold_pulses got=%0d exp=%0d", bus_q.size() - base_q, exp_q.size()); end
    endtask

    task automatic test_timeout();
        respond = 1'b0;
        run_xfer(1'b0, 1'b1, 0, 8'h00, tmo);
        checks++; if (tmo || err_cnt - base_err != 1) begin errors++; $display("FAIL tmo_err got=%0d exp=1", err_cnt - base_err); end
        checks++; if (last_err_cyc - last_en_cyc != ACK_TIMEOUT + 1) begin errors++; $display("FAIL tmo_latency got=%0d exp=%0d", last_err_cyc - last_en_cyc, ACK_TIMEOUT + 1); end
        checks++; if (xfer_busy !== 1'b0 || lcd_bus !== 10'h000) begin errors++; $display("FAIL tmo_end got=%b/%h exp=0/000", xfer_busy, lcd_bus); end
        repeat (20) @(negedge clk);
        #1;
        checks++; if (en_cnt - base_en != 1) begin errors++; $display("FAIL tmo_pulses got=%0d exp=1", en_cnt - base_en); end
        checks++; if (done_cnt != base_done) begin errors++; $display("FAIL tmo_done got=%0d exp=0", done_cnt - base_done); end
        respond = 1'b1;
    endtask

    task automatic test_mid_transfer();
        bit seen;
        build_exp(1'b0, 1'b0);
        mark_base();
        @(negedge clk);
        start = 1'b1; clear_first = 1'b0; line_sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk); #1;
            if (en_cnt - base_en >= 3) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_third_item got=%0d exp=3", en_cnt - base_en); end
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd5; wr_char = ~model_buf[5];
        start = 1'b1; clear_first = 1'b1; line_sel = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        wait_end(tmo);
        checks++; if (tmo || bus_q.size() - base_q != exp_q.size()) begin errors++; $display("FAIL mid_pulses got=%0d exp=%0d", bus_q.size() - base_q, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base_q + i < bus_q.size()) begin
                checks++; if (bus_q[base_q + i] !== exp_q[i]) begin errors++; $display("FAIL mid_item%0d got=%h exp=%h", i, bus_q[base_q + i], exp_q[i]); end
            end
        end
        // second transfer, aborted by reset after the third item
        mark_base();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk); #1;
            if (en_cnt - base_en >= 3) seen = 1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({lcd_enable, xfer_busy, done, err} !== 4'b0000 || lcd_bus !== 10'h000) begin errors++; $display("FAIL mid_reset got=%b/%h exp=0000/000", {lcd_enable, xfer_busy, done, err}, lcd_bus); end
        rst_n = 1'b1;
        model_reset();
        build_exp(1'b0, 1'b0);
        run_xfer(1'b0, 1'b0, 0, 8'h00, tmo);
        checks++; if (tmo || bus_q.size() - base_q != exp_q.size()) begin errors++; $display("FAIL post_rst_pulses got=%0d exp=%0d", bus_q.size() - base_q, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base_q + i < bus_q.size()) begin
                checks++; if (bus_q[base_q + i] !== exp_q[i]) begin errors++; $display("FAIL post_rst_item%0d got=%h exp=%h", i, bus_q[base_q + i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_protocol();
        checks++; if (bad_en != 0) begin errors++; $display("FAIL enable_back_to_back got=%0d exp=0", bad_en); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_line();
        test_hello();
        test_random();
        test_busy_hold();
        test_timeout();
        test_mid_transfer();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
